// File: rtl/max_selector.sv
// Purpose : registered maximum of ten unsigned class scores (comparator tree, no handshake).
// Latency : 1 cycle; the inputs sampled at edge N appear on max after edge N.
// Backpr. : none; a new result is computed every clock and the output cannot stall.
//
// Ports:
//   image_number_0..9 : DATA_W-bit unsigned scores, one per class
//   clk               : system clock; state updates on the rising edge
//   rst               : synchronous, active-high reset; clears max to 0
//   max               : DATA_W-bit registered maximum of the ten scores
module max_selector #(
    parameter int DATA_W = 5
) (
    input  logic [DATA_W-1:0] image_number_0,
    input  logic [DATA_W-1:0] image_number_1,
    input  logic [DATA_W-1:0] image_number_2,
    input  logic [DATA_W-1:0] image_number_3,
    input  logic [DATA_W-1:0] image_number_4,
    input  logic [DATA_W-1:0] image_number_5,
    input  logic [DATA_W-1:0] image_number_6,
    input  logic [DATA_W-1:0] image_number_7,
    input  logic [DATA_W-1:0] image_number_8,
    input  logic [DATA_W-1:0] image_number_9,
    input  logic              clk,
    input  logic              rst,
    output logic [DATA_W-1:0] max
);

    logic [DATA_W-1:0] l1_a, l1_b, l1_c, l1_d, l1_e;
    logic [DATA_W-1:0] l2_a, l2_b;
    logic [DATA_W-1:0] l3_a;
    logic [DATA_W-1:0] max_d, max_q;

    // Balanced tree over ten inputs. The odd pair (8,9) has no partner at
    // levels 2 and 3, so it is carried forward and meets the rest last.
    // Ties resolve to either operand; the values are equal so it does not matter.
    always_comb begin
        l1_a = (image_number_0 > image_number_1) ? image_number_0 : image_number_1;
        l1_b = (image_number_2 > image_number_3) ? image_number_2 : image_number_3;
        l1_c = (image_number_4 > image_number_5) ? image_number_4 : image_number_5;
        l1_d = (image_number_6 > image_number_7) ? image_number_6 : image_number_7;
        l1_e = (image_number_8 > image_number_9) ? image_number_8 : image_number_9;

        l2_a = (l1_a > l1_b) ? l1_a : l1_b;
        l2_b = (l1_c > l1_d) ? l1_c : l1_d;

        l3_a = (l2_a > l2_b) ? l2_a : l2_b;

        max_d = (l3_a > l1_e) ? l3_a : l1_e;
    end

    // Reset wins over the data update, so a result pending at a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q <= '0;
        end else begin
            max_q <= max_d;
        end
    end

    assign max = max_q;

endmodule

// File: tb/tb_max_selector.sv
module tb_max_selector;

    localparam int DATA_W = 5;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] in_dat [10];
    logic [DATA_W-1:0] max_out;

    logic [DATA_W-1:0] exp_q [$];
    int                n_vec;
    int                n_err;
    bit                stim_done;

    max_selector #(.DATA_W(DATA_W)) dut (
        .image_number_0 (in_dat[0]),
        .image_number_1 (in_dat[1]),
        .image_number_2 (in_dat[2]),
        .image_number_3 (in_dat[3]),
        .image_number_4 (in_dat[4]),
        .image_number_5 (in_dat[5]),
        .image_number_6 (in_dat[6]),
        .image_number_7 (in_dat[7]),
        .image_number_8 (in_dat[8]),
        .image_number_9 (in_dat[9]),
        .clk            (clk),
        .rst            (rst),
        .max            (max_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one input set away from the rising edge and queue the value the
    // register must hold once that edge has passed.
    task automatic apply(input logic r,
                         input int v0, input int v1, input int v2, input int v3, input int v4,
                         input int v5, input int v6, input int v7, input int v8, input int v9,
                         input int exp_val);
        @(negedge clk);
        rst       = r;
        in_dat[0] = v0[DATA_W-1:0];
        in_dat[1] = v1[DATA_W-1:0];
        in_dat[2] = v2[DATA_W-1:0];
        in_dat[3] = v3[DATA_W-1:0];
        in_dat[4] = v4[DATA_W-1:0];
        in_dat[5] = v5[DATA_W-1:0];
        in_dat[6] = v6[DATA_W-1:0];
        in_dat[7] = v7[DATA_W-1:0];
        in_dat[8] = v8[DATA_W-1:0];
        in_dat[9] = v9[DATA_W-1:0];
        exp_q.push_back(exp_val[DATA_W-1:0]);
    endtask

    // Monitor: the output refreshes every edge, so each edge that follows a
    // queued stimulus yields exactly one comparison.
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (max_out !== e) begin
                    n_err++;
                    $display("FAIL vec%0d max: got %0d expected %0d", n_vec, max_out, e);
                end
            end
        end
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        stim_done = 1'b0;
        rst       = 1'b1;
        for (int i = 0; i < 10; i++) in_dat[i] = '0;

        // Reset with nonzero inputs: output must read 0 on both edges.
        apply(1'b1, 7, 9, 3, 30, 1, 2, 4, 5, 6, 8, 0);
        apply(1'b1, 7, 9, 3, 30, 1, 2, 4, 5, 6, 8, 0);

        // Directed patterns.
        apply(1'b0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 10);   // max at last input
        apply(1'b0, 1, 2, 3, 4, 5, 14, 7, 8, 9, 10, 14);  // max mid-vector
        apply(1'b0, 1, 13, 3, 4, 5, 6, 7, 8, 9, 0, 13);   // near-front with a zero
        apply(1'b0, 31, 31, 31, 31, 31, 31, 31, 31, 31, 31, 31);
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply(1'b0, 20, 5, 5, 5, 5, 5, 5, 5, 5, 20, 20);  // tie at both ends
        apply(1'b0, 3, 3, 3, 3, 3, 3, 3, 3, 29, 3, 29);   // pass-through pair, idx 8
        apply(1'b0, 15, 15, 15, 15, 15, 15, 15, 15, 15, 16, 16); // MSB decides
        apply(1'b0, 31, 0, 0, 0, 0, 0, 0, 0, 0, 0, 31);   // max at idx 0
        apply(1'b0, 2, 1, 0, 17, 4, 0, 9, 11, 6, 0, 17);  // max at idx 3
        apply(1'b0, 12, 8, 6, 4, 2, 0, 25, 11, 24, 23, 25); // max at idx 6

        // Back-to-back sets: each edge must show the set driven just before it.
        apply(1'b0, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5, 5);
        apply(1'b0, 0, 0, 0, 0, 0, 0, 0, 22, 0, 0, 22);
        apply(1'b0, 1, 1, 1, 1, 30, 1, 1, 1, 1, 1, 30);
        apply(1'b0, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9);

        // Reset mid-stream overrides the nonzero inputs; then recovery.
        apply(1'b1, 9, 8, 7, 6, 5, 4, 3, 2, 1, 27, 0);
        apply(1'b0, 4, 19, 2, 2, 2, 2, 2, 2, 2, 2, 19);

        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
